// File: rtl/mult_hilo_ctrl.sv
// Issue/retire controller for an iterative multiplier: launches MULT/MULTU, captures the
// product into HI/LO, and serves interlocked MFHI/MFLO reads. Define MULT_ACC_EN for MADD/MADDU.
module mult_hilo_ctrl #(
    parameter int WIDTH = 32,
    parameter int LAT   = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             rd_valid,
    input  logic             rd_sel,
    output logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_done,
    output logic [WIDTH-1:0] m_a,
    output logic [WIDTH-1:0] m_b,
    output logic [1:0]       m_sign,
    output logic             m_start,
    input  logic [WIDTH-1:0] m_lower,
    input  logic [WIDTH-1:0] m_higher,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam int            CW       = $clog2(LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_nxt_s;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [WIDTH-1:0]     rd_data_r;
    logic                 rd_done_r;
    logic [WIDTH-1:0]     m_a_r;
    logic [WIDTH-1:0]     m_b_r;
    logic [1:0]           m_sign_r;
    logic                 m_start_r;
    logic                 busy_r;
    logic                 acc_r;

    logic                 req_fire_s;
    logic                 rd_fire_s;
    logic                 op_mul_s;
    logic                 op_mac_s;
    logic                 op_start_s;
    logic                 mthi_s;
    logic                 mtlo_s;
    logic [1:0]           op_sign_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   acc_sum_s;
    logic [2*WIDTH-1:0]   cap_val_s;

    // Request/read decode and the value written to HI:LO at capture.
    always_comb begin
        req_fire_s = req_valid & (state_r == ST_IDLE);
        rd_fire_s  = rd_valid & ~busy_r;
        op_mul_s   = req_fire_s & (req_op[2:1] == 2'b00);
`ifdef MULT_ACC_EN
        op_mac_s   = req_fire_s & (req_op[2:1] == 2'b10);
`else
        op_mac_s   = 1'b0;
`endif
        op_start_s = op_mul_s | op_mac_s;
        mthi_s     = req_fire_s & (req_op == 3'b010);
        mtlo_s     = req_fire_s & (req_op == 3'b011);
        op_sign_s  = req_op[0] ? 2'b11 : 2'b00;
        prod_s     = {m_higher, m_lower};
        acc_sum_s  = {hi_r, lo_r} + prod_s;
        cap_val_s  = acc_r ? acc_sum_s : prod_s;
    end

    // Next-state and latency counter; WAIT lasts LAT-1 cycles so capture lands LAT after m_start.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (op_start_s) begin
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_WAIT;
                cnt_nxt_s   = CNT_LOAD;
            end
            ST_WAIT: begin
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_CAPTURE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_CAPTURE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State register with registered busy/m_start decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            m_start_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            m_start_r <= (state_nxt_s == ST_LAUNCH);
        end
    end

    // Operand latch; held stable for the whole multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a_r    <= '0;
            m_b_r    <= '0;
            m_sign_r <= 2'b00;
            acc_r    <= 1'b0;
        end else if (op_start_s) begin
            m_a_r    <= req_a;
            m_b_r    <= req_b;
            m_sign_r <= op_sign_s;
            acc_r    <= op_mac_s;
        end
    end

    // Architectural HI/LO: product capture or direct MTHI/MTLO writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state_r == ST_CAPTURE) begin
            hi_r <= cap_val_s[2*WIDTH-1:WIDTH];
            lo_r <= cap_val_s[WIDTH-1:0];
        end else begin
            if (mthi_s) begin
                hi_r <= req_a;
            end
            if (mtlo_s) begin
                lo_r <= req_a;
            end
        end
    end

    // Read port samples HI/LO before any same-edge write, so it returns the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
            rd_done_r <= 1'b0;
        end else if (rd_fire_s) begin
            rd_data_r <= rd_sel ? hi_r : lo_r;
            rd_done_r <= 1'b1;
        end else begin
            rd_done_r <= 1'b0;
        end
    end

    assign req_ready = ~busy_r;
    assign rd_ready  = ~busy_r;
    assign rd_data   = rd_data_r;
    assign rd_done   = rd_done_r;
    assign m_a       = m_a_r;
    assign m_b       = m_b_r;
    assign m_sign    = m_sign_r;
    assign m_start   = m_start_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl: reference HI/LO model plus a behavioural fixed-latency
// multiplier that drives garbage on m_lower/m_higher except in the one valid cycle.
module tb_mult_hilo_ctrl;
    localparam int WIDTH = 32;
    localparam int LAT   = 33;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rd_valid;
    logic             rd_sel;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_done;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [1:0]       m_sign;
    logic             m_start;
    logic [WIDTH-1:0] m_lower;
    logic [WIDTH-1:0] m_higher;
    logic             busy;

    mult_hilo_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_done(rd_done),
        .m_a(m_a), .m_b(m_b), .m_sign(m_sign), .m_start(m_start),
        .m_lower(m_lower), .m_higher(m_higher), .busy(busy)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    int          cyc = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;
    int          busy_until = 0;
    int          exp_mstart = -1;
    logic [31:0] exp_ma = 32'd0;
    logic [31:0] exp_mb = 32'd0;
    logic [1:0]  exp_msign = 2'b00;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint      sp;
        logic [63:0] up;
        if (sgn) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            up = sp;
        end else begin
            up = {32'd0, a} * {32'd0, b};
        end
        return up;
    endfunction

    task automatic start_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sg);
        busy_until = cyc + LAT + 2;
        exp_mstart = cyc + 1;
        exp_ma     = a;
        exp_mb     = b;
        exp_msign  = sg;
    endtask

    // Reference model: effect of an accepted request on architectural HI:LO.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000: begin {mhi, mlo} = ref_prod(a, b, 1'b1); start_mul(a, b, 2'b00); end
            3'b001: begin {mhi, mlo} = ref_prod(a, b, 1'b0); start_mul(a, b, 2'b11); end
            3'b010: mhi = a;
            3'b011: mlo = a;
`ifdef MULT_ACC_EN
            3'b100: begin {mhi, mlo} = {mhi, mlo} + ref_prod(a, b, 1'b1); start_mul(a, b, 2'b00); end
            3'b101: begin {mhi, mlo} = {mhi, mlo} + ref_prod(a, b, 1'b0); start_mul(a, b, 2'b11); end
`endif
            default: ;
        endcase
    endtask

    // Behavioural multiplier: product valid only in the cycle LAT after m_start.
    initial begin
        int          cnt;
        bit          pend;
        logic [63:0] p;
        pend = 1'b0; cnt = 0; p = 64'd0;
        m_lower = 32'd0; m_higher = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (pend) cnt--;
            if (m_start === 1'b1) begin
                pend = 1'b1;
                cnt  = LAT;
                if (m_sign == 2'b00)      p = ref_prod(m_a, m_b, 1'b1);
                else if (m_sign == 2'b11) p = ref_prod(m_a, m_b, 1'b0);
                else                      p = {$urandom, $urandom};
            end
            if (pend && cnt == 0) begin
                {m_higher, m_lower} = p;
                pend = 1'b0;
            end else begin
                m_lower  = $urandom;
                m_higher = $urandom;
            end
        end
    end

    // Read monitor: pops the scoreboard whenever the DUT presents rd_done.
    initial begin
        logic [31:0] e;
        int          a;
        forever begin
            @(negedge clk);
            if (rd_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rd_done_spurious", 64'(rd_done), 64'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(e));
                    chk("rd_latency", 64'(cyc), 64'(a + 1));
                end
            end
        end
    end

    // One clock cycle of stimulus with per-cycle control checks; entered at posedge+1.
    task automatic step(input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit rv, input bit rs, output bit acc, output bit racc);
        req_valid = v; req_op = op; req_a = a; req_b = b;
        rd_valid = rv; rd_sel = rs;
        @(negedge clk);
        chk("busy", 64'(busy), 64'(cyc < busy_until));
        chk("req_ready", 64'(req_ready), 64'(cyc >= busy_until));
        chk("rd_ready", 64'(rd_ready), 64'(cyc >= busy_until));
        chk("m_start", 64'(m_start), 64'(cyc == exp_mstart));
        if (cyc == exp_mstart) begin
            chk("m_a", 64'(m_a), 64'(exp_ma));
            chk("m_b", 64'(m_b), 64'(exp_mb));
            chk("m_sign", 64'(m_sign), 64'(exp_msign));
        end
        acc  = v && (req_ready === 1'b1);
        racc = rv && (rd_ready === 1'b1);
        if (racc) begin
            exp_q.push_back(rs ? mhi : mlo);
            acc_q.push_back(cyc);
        end
        if (acc) model_apply(op, a, b);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit ar, rr;
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, ar, rr);
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int acyc);
        bit ar, rr, done;
        int t;
        done = 1'b0; acyc = -1;
        for (int i = 0; i < 200 && !done; i++) begin
            t = cyc;
            step(1'b1, op, a, b, 1'b0, 1'b0, ar, rr);
            if (ar) begin done = 1'b1; acyc = t; end
        end
        chk("req_accept_timeout", 64'(done), 64'(1'b1));
    endtask

    task automatic do_rd(input bit sel, output int acyc);
        bit ar, rr, done;
        int t;
        done = 1'b0; acyc = -1;
        for (int i = 0; i < 200 && !done; i++) begin
            t = cyc;
            step(1'b0, 3'b000, 32'd0, 32'd0, 1'b1, sel, ar, rr);
            if (rr) begin done = 1'b1; acyc = t; end
        end
        chk("rd_accept_timeout", 64'(done), 64'(1'b1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < LAT + 10 && cyc < busy_until; i++) idle(1);
        chk("drain_timeout", 64'(cyc >= busy_until), 64'(1'b1));
    endtask

    initial begin
        int          n, t;
        bit          ar, rr, pend, rv, rs;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] edge_vals [5];
        edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h0000_0001; edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h8000_0000; edge_vals[4] = 32'h7FFF_FFFF;

        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_a = 32'd0; req_b = 32'd0;
        rd_valid = 1'b0; rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_req_ready", 64'(req_ready), 64'(1'b1));
        chk("rst_m_start", 64'(m_start), 64'(1'b0));
        chk("rst_m_a", 64'(m_a), 64'd0);
        chk("rst_m_b", 64'(m_b), 64'd0);
        chk("rst_m_sign", 64'(m_sign), 64'd0);
        chk("rst_rd_done", 64'(rd_done), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        @(posedge clk); #1;
        do_rd(1'b1, t); do_rd(1'b0, t);

        // Signed MULT: -2 * 3
        do_req(3'b000, 32'hFFFF_FFFE, 32'd3, n);
        wait_idle();
        do_rd(1'b1, t); do_rd(1'b0, t);

        // MULTU max*max, with an MTHI held until the slot frees; a same-cycle MFHI sees the product
        do_req(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        ar = 1'b0;
        t  = -1;
        for (int i = 0; i < 200 && !ar; i++) begin
            t = cyc;
            step(1'b1, 3'b010, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b1, ar, rr);
        end
        chk("held_accept_cycle", 64'(t), 64'(n + LAT + 2));
        chk("held_read_same_cycle", 64'(rr), 64'(1'b1));
        do_rd(1'b0, t); do_rd(1'b1, t);

        // MTLO with same-cycle MFLO, then MFLO next cycle
        step(1'b1, 3'b011, 32'h1234_5678, 32'd0, 1'b1, 1'b0, ar, rr);
        chk("mtlo_accept", 64'({ar, rr}), 64'(2'b11));
        do_rd(1'b0, t);

        // MFHI during WAIT is held off until busy falls
        do_req(3'b000, $urandom, $urandom, n);
        idle(LAT / 2);
        do_rd(1'b1, t);
        chk("rd_interlock_release", 64'(t), 64'(n + LAT + 2));

        // Reset at the middle of WAIT: stale product must never land
        do_req(3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D, n);
        idle(LAT / 2);
        rst_n = 1'b0;
        mhi = 32'd0; mlo = 32'd0; busy_until = 0; exp_mstart = -1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'(1'b0));
        chk("midrst_m_start", 64'(m_start), 64'(1'b0));
        @(posedge clk); cyc++; #1;
        rst_n = 1'b1;
        idle(LAT + 4);
        do_rd(1'b1, t); do_rd(1'b0, t);

        // Accumulate op and the 1xx encodings (no-ops unless MULT_ACC_EN)
        do_req(3'b010, 32'd0, 32'd0, n);
        do_req(3'b011, 32'hFFFF_FFFF, 32'd0, n);
        do_req(3'b101, 32'd1, 32'd1, n);
        wait_idle();
        do_rd(1'b1, t); do_rd(1'b0, t);
        do_req(3'b100, 32'hFFFF_FFFF, 32'h0000_0005, n);
        wait_idle();
        do_req(3'b110, 32'h5555_5555, 32'd0, n);
        do_req(3'b111, 32'hAAAA_AAAA, 32'd0, n);
        do_rd(1'b1, t); do_rd(1'b0, t);

        // Randomized traffic; a pending request is held until accepted
        pend = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1'b1;
                op   = 3'($urandom_range(0, 7));
                a    = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : 32'($urandom);
                b    = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : 32'($urandom);
            end
            rv = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            step(pend, op, a, b, rv, rs, ar, rr);
            if (ar) pend = 1'b0;
        end
        wait_idle();
        idle(3);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
